pipeline_latealu: RTL and testbench



---
 rtl/pipeline_latealu.sv | 199 +++++++++++++++++++
 tb/tb_pipeline_latealu.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_latealu.sv
// Late-ALU stage: one-cycle barrel shifts plus iterative mult/div on private HI/LO registers.
// Divider datapath (ops div/divu) is built only when PIPELINE_LATEALU_DIV_EN is defined.
module pipeline_latealu (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_index_in,
  input  logic [31:0] rd_value_in,
  input  logic [2:0]  exception_in,
  input  logic        latealu_enable,
  input  logic [5:0]  latealu_op,
  input  logic [31:0] latealu_a0,
  input  logic [31:0] latealu_a1,
  output logic [4:0]  rd_index,
  output logic [31:0] rd_value,
  output logic [2:0]  exception,
  output logic        stall,
  output logic        busy
);

  localparam logic [5:0] OP_SLL   = 6'd1;
  localparam logic [5:0] OP_SRL   = 6'd2;
  localparam logic [5:0] OP_SRA   = 6'd3;
  localparam logic [5:0] OP_MULT  = 6'd4;
  localparam logic [5:0] OP_MULTU = 6'd5;
  localparam logic [5:0] OP_DIV   = 6'd6;
  localparam logic [5:0] OP_DIVU  = 6'd7;
  localparam logic [5:0] OP_MFHI  = 6'd8;
  localparam logic [5:0] OP_MFLO  = 6'd9;
  localparam logic [5:0] OP_MTHI  = 6'd10;
  localparam logic [5:0] OP_MTLO  = 6'd11;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t      state;
  logic [4:0]  count;
  logic [31:0] hi, lo, opnd;
  logic [63:0] prod;
  logic        neg_lo;
  logic        md_op, hilo_op, is_signed, start_md;
  logic [31:0] mag_a, mag_b, shift_res, fix_hi, fix_lo;
  logic [32:0] add_sum;
  logic [63:0] mult_next, iter_next, prod_neg;
`ifdef PIPELINE_LATEALU_DIV_EN
  logic        is_div, neg_hi;
  logic [32:0] div_shift, div_diff;
  logic [63:0] div_next;
`endif

  always_comb begin
    md_op     = (latealu_op == OP_MULT) || (latealu_op == OP_MULTU);
    is_signed = (latealu_op == OP_MULT);
`ifdef PIPELINE_LATEALU_DIV_EN
    md_op     = md_op || (latealu_op == OP_DIV) || (latealu_op == OP_DIVU);
    is_signed = is_signed || (latealu_op == OP_DIV);
`endif
    hilo_op   = md_op || ((latealu_op >= OP_MFHI) && (latealu_op <= OP_MTLO));
  end

  // Only ops touching HI/LO wait on the background unit; everything else flows.
  assign stall    = latealu_enable && (exception_in == 3'd0) && busy && hilo_op;
  assign start_md = latealu_enable && (exception_in == 3'd0) && !busy && md_op;

  assign mag_a = (is_signed && latealu_a0[31]) ? -latealu_a0 : latealu_a0;
  assign mag_b = (is_signed && latealu_a1[31]) ? -latealu_a1 : latealu_a1;

  always_comb begin
    shift_res = 32'd0;
    case (latealu_op)
      OP_SLL:  shift_res = latealu_a0 << latealu_a1[4:0];
      OP_SRL:  shift_res = latealu_a0 >> latealu_a1[4:0];
      OP_SRA:  shift_res = $signed(latealu_a0) >>> latealu_a1[4:0];
      default: shift_res = 32'd0;
    endcase
  end

  // Shift-add multiplier: prod holds {partial sum, remaining multiplier bits}.
  assign add_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd} : 33'd0);
  assign mult_next = {add_sum, prod[31:1]};
  assign prod_neg  = -prod;

`ifdef PIPELINE_LATEALU_DIV_EN
  // Restoring divider: prod holds {remainder, dividend bits shifting into quotient}.
  assign div_shift = prod[63:31];
  assign div_diff  = div_shift - {1'b0, opnd};
  always_comb begin
    if (div_shift >= {1'b0, opnd})
      div_next = {div_diff[31:0], prod[30:0], 1'b1};
    else
      div_next = {div_shift[31:0], prod[30:0], 1'b0};
  end
  assign iter_next = is_div ? div_next : mult_next;
`else
  assign iter_next = mult_next;
`endif

  always_comb begin
    {fix_hi, fix_lo} = neg_lo ? prod_neg : prod;
`ifdef PIPELINE_LATEALU_DIV_EN
    if (is_div) begin
      fix_lo = neg_lo ? -prod[31:0] : prod[31:0];
      fix_hi = neg_hi ? -prod[63:32] : prod[63:32];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_index  <= 5'd0;
      rd_value  <= 32'd0;
      exception <= 3'd0;
      busy      <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      opnd      <= 32'd0;
      prod      <= 64'd0;
      neg_lo    <= 1'b0;
      count     <= 5'd0;
      state     <= IDLE;
`ifdef PIPELINE_LATEALU_DIV_EN
      is_div    <= 1'b0;
      neg_hi    <= 1'b0;
`endif
    end else begin
      if (stall) begin
        rd_index  <= 5'd0;
        rd_value  <= 32'd0;
        exception <= 3'd0;
      end else if (!latealu_enable) begin
        rd_index  <= rd_index_in;
        rd_value  <= rd_value_in;
        exception <= exception_in;
      end else if (exception_in != 3'd0) begin
        rd_index  <= 5'd0;
        rd_value  <= rd_value_in;
        exception <= exception_in;
      end else begin
        rd_index  <= 5'd0;
        rd_value  <= 32'd0;
        exception <= 3'd0;
        case (latealu_op)
          OP_SLL, OP_SRL, OP_SRA: begin
            rd_index <= rd_index_in;
            rd_value <= shift_res;
          end
          OP_MFHI: begin
            rd_index <= rd_index_in;
            rd_value <= hi;
          end
          OP_MFLO: begin
            rd_index <= rd_index_in;
            rd_value <= lo;
          end
          OP_MTHI: hi <= latealu_a0;
          OP_MTLO: lo <= latealu_a0;
          OP_MULT, OP_MULTU: ;
`ifdef PIPELINE_LATEALU_DIV_EN
          OP_DIV, OP_DIVU: ;
`endif
          default: exception <= 3'b001;
        endcase
      end

      // Background unit; mthi/mtlo cannot coincide with FIX since they stall while busy.
      case (state)
        IDLE: begin
          if (start_md) begin
            state  <= ITER;
            count  <= 5'd0;
            busy   <= 1'b1;
            prod   <= {32'd0, mag_b};
            opnd   <= mag_a;
            neg_lo <= is_signed && (latealu_a0[31] ^ latealu_a1[31]);
`ifdef PIPELINE_LATEALU_DIV_EN
            is_div <= (latealu_op == OP_DIV) || (latealu_op == OP_DIVU);
            neg_hi <= is_signed && latealu_a0[31];
            if ((latealu_op == OP_DIV) || (latealu_op == OP_DIVU)) begin
              prod <= {32'd0, mag_a};
              opnd <= mag_b;
            end
`endif
          end
        end
        ITER: begin
          prod  <= iter_next;
          count <= count + 5'd1;
          if (count == 5'd31) state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_latealu.sv
// Randomized self-checking bench for pipeline_latealu against an arithmetic HI/LO model.
// Divide checks follow PIPELINE_LATEALU_DIV_EN the same way the design does.
module tb_pipeline_latealu;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_index_in;
  logic [31:0] rd_value_in;
  logic [2:0]  exception_in;
  logic        latealu_enable;
  logic [5:0]  latealu_op;
  logic [31:0] latealu_a0, latealu_a1;
  logic [4:0]  rd_index;
  logic [31:0] rd_value;
  logic [2:0]  exception;
  logic        stall, busy;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_pend;
  logic [4:0]  e_idx;
  logic [31:0] e_val;
  logic [2:0]  e_exc;
  logic        e_care, e_stall, e_busy;
  logic        last_stall;

`ifdef PIPELINE_LATEALU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  pipeline_latealu dut (
    .clk(clk), .rst(rst),
    .rd_index_in(rd_index_in), .rd_value_in(rd_value_in), .exception_in(exception_in),
    .latealu_enable(latealu_enable), .latealu_op(latealu_op),
    .latealu_a0(latealu_a0), .latealu_a1(latealu_a1),
    .rd_index(rd_index), .rd_value(rd_value), .exception(exception),
    .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_md(input logic [5:0] op);
    return (op == 6'd4) || (op == 6'd5) || (DIV_ON && ((op == 6'd6) || (op == 6'd7)));
  endfunction

  function automatic bit is_hilo(input logic [5:0] op);
    return is_md(op) || ((op >= 6'd8) && (op <= 6'd11));
  endfunction

  // Plain arithmetic reference: the final HI/LO of a mult/div, applied 33 edges after acceptance.
  task automatic computeMd(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] up;
    logic signed [31:0] qa, qb;
    case (op)
      6'd4: begin
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        sp = sa * sb;
        {m_phi, m_plo} = sp;
      end
      6'd5: begin
        up = {32'd0, a} * {32'd0, b};
        {m_phi, m_plo} = up;
      end
      6'd6: begin
        qa = $signed(a);
        qb = $signed(b);
        if (b == 32'd0) begin
          m_phi = a;
          m_plo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_phi = 32'd0;
          m_plo = 32'h8000_0000;
        end else begin
          m_plo = qa / qb;
          m_phi = qa % qb;
        end
      end
      default: begin
        if (b == 32'd0) begin
          m_phi = a;
          m_plo = 32'hFFFF_FFFF;
        end else begin
          m_plo = a / b;
          m_phi = a % b;
        end
      end
    endcase
  endtask

  task automatic modelStep();
    bit busy_now;
    logic [63:0] wide;
    busy_now = (m_pend > 0);
    e_stall  = latealu_enable && (exception_in == 3'd0) && busy_now && is_hilo(latealu_op);
    e_care   = 1'b1;
    e_idx    = 5'd0;
    e_val    = 32'd0;
    e_exc    = 3'd0;
    if (rst) begin
      m_hi = 32'd0; m_lo = 32'd0; m_pend = 0;
    end else begin
      if (e_stall) begin
        e_idx = 5'd0;
      end else if (!latealu_enable) begin
        e_idx = rd_index_in; e_val = rd_value_in; e_exc = exception_in;
      end else if (exception_in != 3'd0) begin
        e_val = rd_value_in; e_exc = exception_in;
      end else begin
        case (latealu_op)
          6'd1: begin wide = {32'd0, latealu_a0} << latealu_a1[4:0]; e_idx = rd_index_in; e_val = wide[31:0]; end
          6'd2: begin wide = {32'd0, latealu_a0} >> latealu_a1[4:0]; e_idx = rd_index_in; e_val = wide[31:0]; end
          6'd3: begin wide = {{32{latealu_a0[31]}}, latealu_a0} >> latealu_a1[4:0]; e_idx = rd_index_in; e_val = wide[31:0]; end
          6'd8: begin e_idx = rd_index_in; e_val = m_hi; end
          6'd9: begin e_idx = rd_index_in; e_val = m_lo; end
          6'd10: begin m_hi = latealu_a0; e_care = 1'b0; end
          6'd11: begin m_lo = latealu_a0; e_care = 1'b0; end
          default: begin
            e_care = 1'b0;
            if (!is_md(latealu_op)) e_exc = 3'b001;
          end
        endcase
      end
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin m_hi = m_phi; m_lo = m_plo; end
      end
      if (!busy_now && latealu_enable && exception_in == 3'd0 && is_md(latealu_op)) begin
        computeMd(latealu_op, latealu_a0, latealu_a1);
        m_pend = 33;
      end
    end
    e_busy = (m_pend > 0);
  endtask

  task automatic checkOutput();
    check("rd_index", {59'd0, rd_index}, {59'd0, e_idx});
    check("exception", {61'd0, exception}, {61'd0, e_exc});
    check("busy", {63'd0, busy}, {63'd0, e_busy});
    if (e_care) check("rd_value", {32'd0, rd_value}, {32'd0, e_val});
  endtask

  task automatic stepCycle();
    #1;
    modelStep();
    check("stall", {63'd0, stall}, {63'd0, e_stall});
    last_stall = stall;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic [5:0] op,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [4:0] idx, input logic [2:0] exc);
    rst = r; latealu_enable = en; latealu_op = op;
    latealu_a0 = a0; latealu_a1 = a1;
    rd_index_in = idx; rd_value_in = $urandom; exception_in = exc;
    stepCycle();
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a0, input logic [31:0] a1, input logic [4:0] idx);
    applyStimulus(1'b0, 1'b1, op, a0, a1, idx, 3'd0);
  endtask

  // Holds a HI/LO op until accepted; returns the number of stall cycles seen.
  task automatic issueWait(input logic [5:0] op, input logic [4:0] idx, output int stalls);
    stalls = 0;
    issue(op, 32'd0, 32'd0, idx);
    while (last_stall && stalls < 60) begin
      stalls++;
      stepCycle();
    end
    if (last_stall) check("wait_budget", 64'd1, 64'd0);
  endtask

  initial begin
    int stalls;
    logic [5:0] rop;
    logic [31:0] ra0, ra1;
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pend = 0; last_stall = 1'b0;

    applyStimulus(1'b1, 1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 3'd0);
    applyStimulus(1'b1, 1'b1, 6'd9, 32'd0, 32'd0, 5'd3, 3'd0);
    check("reset_rd_value", {32'd0, rd_value}, 64'd0);

    issue(6'd1, 32'h0000_0001, 32'd31, 5'd5);
    check("sll_lit_idx", {59'd0, rd_index}, 64'd5);
    check("sll_lit_val", {32'd0, rd_value}, 64'h8000_0000);
    issue(6'd3, 32'h8000_0000, 32'hFFFF_FFE4, 5'd6);
    check("sra_lit", {32'd0, rd_value}, 64'hF800_0000);
    issue(6'd2, 32'h8000_0000, 32'hFFFF_FFE4, 5'd6);
    check("srl_lit", {32'd0, rd_value}, 64'h0800_0000);

    issue(6'd4, 32'hFFFF_FFFD, 32'd7, 5'd9);
    issueWait(6'd9, 5'd2, stalls);
    check("mult_stall_cycles", 64'(stalls), 64'd33);
    check("mflo_lit", {32'd0, rd_value}, 64'hFFFF_FFEB);
    issueWait(6'd8, 5'd2, stalls);
    check("mfhi_lit", {32'd0, rd_value}, 64'hFFFF_FFFF);

    issue(6'd0, 32'd1, 32'd1, 5'd4);
    check("illegal_op_exc", {61'd0, exception}, 64'd1);

`ifdef PIPELINE_LATEALU_DIV_EN
    issue(6'd7, 32'd100, 32'd7, 5'd0);
    issueWait(6'd9, 5'd1, stalls);
    check("divu_lo_lit", {32'd0, rd_value}, 64'd14);
    issueWait(6'd8, 5'd1, stalls);
    check("divu_hi_lit", {32'd0, rd_value}, 64'd2);
    issue(6'd6, 32'hFFFF_FFF9, 32'd2, 5'd0);
    issueWait(6'd9, 5'd1, stalls);
    check("div_lo_lit", {32'd0, rd_value}, 64'hFFFF_FFFD);
    issueWait(6'd8, 5'd1, stalls);
    check("div_hi_lit", {32'd0, rd_value}, 64'hFFFF_FFFF);
    issue(6'd7, 32'd5, 32'd0, 5'd0);
    issueWait(6'd9, 5'd1, stalls);
    check("divu0_lo_lit", {32'd0, rd_value}, 64'hFFFF_FFFF);
    issueWait(6'd8, 5'd1, stalls);
    check("divu0_hi_lit", {32'd0, rd_value}, 64'd5);
    issue(6'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    issueWait(6'd9, 5'd1, stalls);
    check("div_ovf_lo_lit", {32'd0, rd_value}, 64'h8000_0000);
`else
    issue(6'd6, 32'd100, 32'd7, 5'd3);
    check("div_off_exc", {61'd0, exception}, 64'd1);
`endif

    issue(6'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    stalls = 0;
    for (int i = 0; i < 12; i++) begin
      issue(6'd1, $urandom, $urandom, 5'(i + 1));
      if (last_stall) stalls++;
    end
    check("shift_nostall_lit", 64'(stalls), 64'd0);
    issueWait(6'd8, 5'd7, stalls);
    check("multu_hi_lit", {32'd0, rd_value}, 64'hFFFF_FFFE);

    issue(6'd4, 32'd1234, 32'd5678, 5'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 3'd0);
    applyStimulus(1'b1, 1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 3'd0);
    check("abort_busy_lit", {63'd0, busy}, 64'd0);
    issue(6'd8, 32'd0, 32'd0, 5'd8);
    check("abort_stall_lit", {63'd0, last_stall}, 64'd0);
    check("abort_hi_lit", {32'd0, rd_value}, 64'd0);

    for (int i = 0; i < 3000; i++) begin
      if (last_stall) begin
        stepCycle();
      end else begin
        rop = 6'($urandom_range(0, 13));
        ra0 = $urandom;
        ra1 = $urandom;
        if ($urandom_range(0, 7) == 0) ra1 = 32'd0;
        if ($urandom_range(0, 7) == 0) ra0 = 32'h8000_0000;
        if ($urandom_range(0, 7) == 0) ra1 = 32'hFFFF_FFFF;
        applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 5) != 0, rop, ra0, ra1,
                      5'($urandom), ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
